// File: rtl/alu_pkg.sv
// Shared constants for the ALU result routing datapath: channel count,
// select width and the select encoding used to steer result words.
package alu_pkg;

  localparam int ALU_NUM_CH = 4;
  localparam int ALU_SEL_W  = 2;

  localparam logic [ALU_SEL_W-1:0] SEL_CH0 = 2'd0;
  localparam logic [ALU_SEL_W-1:0] SEL_CH1 = 2'd1;
  localparam logic [ALU_SEL_W-1:0] SEL_CH2 = 2'd2;
  localparam logic [ALU_SEL_W-1:0] SEL_CH3 = 2'd3;

endpackage

// File: rtl/alu_result_demux_fifo.sv
// Per-channel FIFO for the result router; a pushed word is visible at the head one cycle later.
// Backpressure: the pusher must respect full_o; a full FIFO ignores push even while popping.
module demux_chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             vld_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign vld_o      = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];

  // Full is judged on registered state only, so a same-cycle pop never frees the slot.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && vld_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/alu_result_demux.sv
// 1-to-4 registered result router; one cycle from push to out_valid, no bypass.
// Backpressure: in_ready drops only while the selected channel is full; channels stall independently.
module alu_result_demux
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ALU_SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]            in_data,
  output logic [ALU_NUM_CH-1:0]       out_valid,
  input  logic [ALU_NUM_CH-1:0]       out_ready,
  output logic [ALU_NUM_CH*WIDTH-1:0] out_data,
  output logic [ALU_NUM_CH-1:0]       chan_full
);

  logic [ALU_NUM_CH-1:0] push_en;

  assign in_ready = !chan_full[in_sel];

  always_comb begin
    push_en = '0;
    if (in_valid && in_ready) begin
      case (in_sel)
        SEL_CH0: push_en[0] = 1'b1;
        SEL_CH1: push_en[1] = 1'b1;
        SEL_CH2: push_en[2] = 1'b1;
        SEL_CH3: push_en[3] = 1'b1;
        default: push_en    = '0;
      endcase
    end
  end

  for (genvar k = 0; k < ALU_NUM_CH; k++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push_en[k]),
      .push_dat_i(in_data),
      .pop_i     (out_ready[k]),
      .head_dat_o(out_data[k*WIDTH +: WIDTH]),
      .vld_o     (out_valid[k]),
      .full_o    (chan_full[k])
    );
  end

endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: directed scenarios plus random traffic,
// each checked against a per-channel queue model of the router.
module tb_alu_result_demux;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_sel = 2'd0;
  logic [WIDTH-1:0]  in_data = '0;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready = 4'b0;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]        chan_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mq [4][$];

  alu_result_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .chan_full(chan_full)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (mq[k].size() > 0);
    return v;
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (mq[k].size() == DEPTH);
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] chan_dat(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] ordy);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Advance the model by the transfers implied by current inputs, then clock.
  task automatic tick();
    bit acc;
    acc = in_valid && (mq[in_sel].size() < DEPTH);
    for (int k = 0; k < 4; k++)
      if (out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
    if (acc) mq[in_sel].push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) mq[k].delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0000", out_valid);
    end
    n_checks++;
    if (chan_full !== 4'b0000) begin
      n_fail++; $display("FAIL reset_chan_full: got %b want 0000", chan_full);
    end
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 2'(s), '0, 4'b0);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, in_ready);
      end
    end
  endtask

  task automatic test_single_push();
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (out_valid !== 4'b0100) begin
      n_fail++; $display("FAIL single_valid: got %b want 0100", out_valid);
    end
    n_checks++;
    if (out_data[95:64] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_data: got %h want deadbeef", out_data[95:64]);
    end
    drive(1'b0, 2'd0, '0, 4'b0100);
    tick();
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL single_drain: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_fill();
    drive(1'b1, 2'd1, 32'h1, 4'b0); tick();
    drive(1'b1, 2'd1, 32'h2, 4'b0); tick();
    drive(1'b0, 2'd1, '0, 4'b0);
    n_checks++;
    if (chan_full !== 4'b0010) begin
      n_fail++; $display("FAIL fill_full: got %b want 0010", chan_full);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_rdy_sel1: got %b want 0", in_ready);
    end
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_rdy_sel0: got %b want 1", in_ready);
    end
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 2'd0, '0, 4'b0010);
      n_checks++;
      if (out_valid[1] !== 1'b1 || chan_dat(1) !== 32'(i)) begin
        n_fail++; $display("FAIL fill_drain%0d: got v=%b d=%h want v=1 d=%h", i, out_valid[1], chan_dat(1), i);
      end
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (out_valid !== 4'b0000 || chan_full !== 4'b0000) begin
      n_fail++; $display("FAIL fill_empty: got v=%b f=%b want 0000/0000", out_valid, chan_full);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i <= 16; i++) begin
      drive(i < 16, 2'd3, 32'h10 + 32'(i), 4'b1000);
      if (i < 16) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_rdy%0d: got %b want 1", i, in_ready);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (out_valid[3] !== 1'b1 || chan_dat(3) !== 32'h10 + 32'(i - 1)) begin
          n_fail++; $display("FAIL stream_out%0d: got v=%b d=%h want v=1 d=%h", i, out_valid[3], chan_dat(3), 32'h10 + 32'(i - 1));
        end
      end
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL stream_end: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_independence();
    drive(1'b1, 2'd0, 32'hA0A0_0001, 4'b0); tick();
    drive(1'b1, 2'd0, 32'hA0A0_0002, 4'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, (i % 2 == 0) ? 2'd1 : 2'd2, 32'hB000_0000 + 32'(i), 4'b0110);
      for (int k = 1; k <= 2; k++) begin
        n_checks++;
        if (out_valid[k] !== (mq[k].size() > 0) ||
            (mq[k].size() > 0 && chan_dat(k) !== mq[k][0])) begin
          n_fail++; $display("FAIL indep_ch%0d_c%0d: got v=%b d=%h want v=%b", k, i, out_valid[k], chan_dat(k), mq[k].size() > 0);
        end
      end
      tick();
    end
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (chan_full !== 4'b0001 || chan_dat(0) !== 32'hA0A0_0001 || out_valid !== 4'b0001) begin
      n_fail++; $display("FAIL indep_ch0_hold: got f=%b v=%b d=%h want 0001/0001/a0a00001", chan_full, out_valid, chan_dat(0));
    end
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 2'd0, '0, 4'b0001);
      n_checks++;
      if (chan_dat(0) !== 32'hA0A0_0000 + 32'(i)) begin
        n_fail++; $display("FAIL indep_ch0_drain%0d: got %h want %h", i, chan_dat(0), 32'hA0A0_0000 + 32'(i));
      end
      tick();
    end
  endtask

  task automatic test_full_pushpop();
    drive(1'b1, 2'd1, 32'hC1, 4'b0); tick();
    drive(1'b1, 2'd1, 32'hC2, 4'b0); tick();
    drive(1'b1, 2'd1, 32'hC3, 4'b0010);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fpp_rdy_full: got %b want 0", in_ready);
    end
    tick();
    drive(1'b1, 2'd1, 32'hC3, 4'b0);
    n_checks++;
    if (in_ready !== 1'b1 || chan_full[1] !== 1'b0) begin
      n_fail++; $display("FAIL fpp_rdy_after: got r=%b f=%b want 1/0", in_ready, chan_full[1]);
    end
    tick();
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (chan_full[1] !== 1'b1 || chan_dat(1) !== 32'hC2) begin
      n_fail++; $display("FAIL fpp_refill: got f=%b d=%h want 1/c2", chan_full[1], chan_dat(1));
    end
    for (int i = 2; i <= 3; i++) begin
      drive(1'b0, 2'd0, '0, 4'b0010);
      n_checks++;
      if (chan_dat(1) !== 32'hC0 + 32'(i)) begin
        n_fail++; $display("FAIL fpp_drain%0d: got %h want %h", i, chan_dat(1), 32'hC0 + 32'(i));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd0, 32'h11, 4'b0); tick();
    drive(1'b1, 2'd0, 32'h12, 4'b0); tick();
    drive(1'b1, 2'd1, 32'h21, 4'b0); tick();
    drive(1'b1, 2'd2, 32'h31, 4'b0); tick();
    drive(1'b1, 2'd3, 32'h41, 4'b0); tick();
    drive(1'b0, 2'd0, '0, 4'b0);
    rst_n = 1'b0;
    #1;
    clear_model();
    n_checks++;
    if (out_valid !== 4'b0000 || chan_full !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid: got v=%b f=%b want 0000/0000", out_valid, chan_full);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rst_release: got %b want 0000", out_valid);
    end
    @(posedge clk); #1;
    drive(1'b1, 2'd1, 32'h5A5A, 4'b0); tick();
    drive(1'b0, 2'd0, '0, 4'b0);
    n_checks++;
    if (out_valid !== 4'b0010 || chan_dat(1) !== 32'h5A5A) begin
      n_fail++; $display("FAIL rst_first_push: got v=%b d=%h want 0010/5a5a", out_valid, chan_dat(1));
    end
    drive(1'b0, 2'd0, '0, 4'b0010); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, 4'($urandom));
      n_checks++;
      if (out_valid !== exp_valid() || chan_full !== exp_full() ||
          in_ready !== (mq[in_sel].size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ctl c%0d: got v=%b f=%b r=%b want v=%b f=%b", c, out_valid, chan_full, in_ready, exp_valid(), exp_full());
      end
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() > 0) begin
          n_checks++;
          if (chan_dat(k) !== mq[k][0]) begin
            n_fail++; $display("FAIL rand_data c%0d ch%0d: got %h want %h", c, k, chan_dat(k), mq[k][0]);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_push();
    test_fill();
    test_stream();
    test_independence();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
